// File: rtl/register_dump_reader.sv
// Streams register file entries startReg..endReg (mod 32) onto a valid/ready port, two words per READ.
// First word is valid two edges after start; a low dumpReady holds the current word unchanged.
module register_dump_reader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       startReg,
    input  logic [4:0]       endReg,
    output logic [4:0]       readReg1,
    output logic [4:0]       readReg2,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    output logic [WIDTH-1:0] dumpData,
    output logic [4:0]       dumpAddr,
    output logic             dumpValid,
    input  logic             dumpReady,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [4:0]       r_ptr;
    logic [5:0]       r_remaining;
    logic [WIDTH-1:0] r_buf1;
    logic [WIDTH-1:0] r_buf2;
    logic [4:0]       r_rd1;
    logic [4:0]       r_rd2;
    logic [4:0]       w_ptr_p1;
    logic [4:0]       w_span;
    logic             w_accept;
    logic             w_last;

    assign w_ptr_p1 = r_ptr + 5'd1;
    assign w_span   = endReg - startReg;
    assign w_accept = dumpValid & dumpReady;
    assign w_last   = (r_remaining == 6'd1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = READ;
            READ:    w_next = SEND1;
            SEND1:   if (w_accept) w_next = w_last ? DONE : SEND2;
            SEND2:   if (w_accept) w_next = w_last ? DONE : READ;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        dumpValid = 1'b0;
        dumpData  = '0;
        dumpAddr  = '0;
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        // Read addresses are live only in READ; elsewhere they show the last pair issued.
        readReg1  = (r_state == READ) ? r_ptr    : r_rd1;
        readReg2  = (r_state == READ) ? w_ptr_p1 : r_rd2;
        case (r_state)
            SEND1: begin
                dumpValid = 1'b1;
                dumpData  = r_buf1;
                dumpAddr  = r_ptr;
            end
            SEND2: begin
                dumpValid = 1'b1;
                dumpData  = r_buf2;
                dumpAddr  = w_ptr_p1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_buf1      <= '0;
            r_buf2      <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr       <= startReg;
                        // Span is 1..32 words; a 6-bit count avoids aliasing 32 to 0.
                        r_remaining <= {1'b0, w_span} + 6'd1;
                    end
                end
                READ: begin
                    r_buf1 <= readData1;
                    r_buf2 <= readData2;
                    r_rd1  <= r_ptr;
                    r_rd2  <= w_ptr_p1;
                end
                SEND1: begin
                    if (w_accept) r_remaining <= r_remaining - 6'd1;
                end
                SEND2: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 6'd1;
                        r_ptr       <= r_ptr + 5'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_dump_reader.sv
// Bench for register_dump_reader: modelled register file, scoreboard of expected words and read pairs.
module tb_register_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  startReg;
    logic [4:0]  endReg;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] dumpData;
    logic [4:0]  dumpAddr;
    logic        dumpValid;
    logic        dumpReady;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [9:0] rd_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int n_acc    = 0;
    int n_done   = 0;
    int cyc_cnt  = 0;
    int t_start  = 0;
    bit prev_stall = 0;

    register_dump_reader #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .startReg  (startReg),
        .endReg    (endReg),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .dumpData  (dumpData),
        .dumpAddr  (dumpAddr),
        .dumpValid (dumpValid),
        .dumpReady (dumpReady),
        .busy      (busy),
        .done      (done)
    );

    assign readData1 = regs[readReg1];
    assign readData2 = regs[readReg2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: compare every valid word against the scoreboard head, pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dumpValid) begin
                if (sb_q.size() == 0) begin
                    chk_eq("spurious_valid", 1, 0);
                end else begin
                    chk_eq("dump_addr", dumpAddr, sb_q[0].addr);
                    chk_eq("dump_data", dumpData, sb_q[0].data);
                    if (dumpReady) begin
                        void'(sb_q.pop_front());
                        n_acc++;
                    end
                end
            end
            if (prev_stall) chk_eq("stall_valid_held", dumpValid, 1);
            prev_stall = dumpValid && !dumpReady;
            if (busy && !dumpValid && !done) begin
                if (rd_q.size() == 0) begin
                    chk_eq("spurious_read", 1, 0);
                end else begin
                    chk_eq("read_pair", {readReg1, readReg2}, rd_q[0]);
                    void'(rd_q.pop_front());
                end
            end
            if (done) n_done++;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [4:0] s, input logic [4:0] e);
        int n;
        logic [4:0] a;
        n = int'(5'(e - s)) + 1;
        for (int i = 0; i < n; i++) begin
            exp_t x;
            a = 5'(s + 5'(i));
            x.addr = a;
            x.data = regs[a];
            sb_q.push_back(x);
        end
        for (int i = 0; i < n; i += 2) begin
            a = 5'(s + 5'(i));
            rd_q.push_back({a, 5'(a + 5'd1)});
        end
        startReg = s;
        endReg   = e;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        t_start  = cyc_cnt;
        startReg = 5'($urandom);
        endReg   = 5'($urandom);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int guard = 0;
        while (!done && guard < 2000) begin
            tick();
            guard++;
        end
        if (!done) begin
            chk_eq({tag, "_timeout"}, 0, 1);
        end else begin
            chk_eq({tag, "_latency"}, cyc_cnt - t_start, exp_lat);
            tick();
            chk_eq({tag, "_done_pulse"}, done, 0);
            chk_eq({tag, "_idle"}, busy, 0);
        end
        chk_eq({tag, "_sb_empty"}, sb_q.size(), 0);
        chk_eq({tag, "_rd_empty"}, rd_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        int guard;
        for (int k = 0; k < 32; k++) regs[k] = 32'(k + 1);
        rst_n = 1'b0; start = 1'b0; dumpReady = 1'b1; startReg = '0; endReg = '0;
        repeat (3) tick();
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_valid", dumpValid, 0);
        chk_eq("rst_data", dumpData, 0);
        chk_eq("rst_addr", dumpAddr, 0);
        chk_eq("rst_rr1", readReg1, 0);
        chk_eq("rst_rr2", readReg2, 0);
        rst_n = 1'b1;
        tick();

        // Full 0..31 dump at full throughput.
        base = n_acc;
        start_dump(5'd0, 5'd31);
        chk_eq("full_busy", busy, 1);
        wait_done("full", 48);
        chk_eq("full_words", n_acc - base, 32);

        // Wrap-around 30..1.
        base = n_acc;
        start_dump(5'd30, 5'd1);
        wait_done("wrap", 6);
        chk_eq("wrap_words", n_acc - base, 4);
        chk_eq("wrap_hold_rr1", readReg1, 0);
        chk_eq("wrap_hold_rr2", readReg2, 1);

        // Single word; DONE follows SEND1 directly.
        base = n_acc;
        start_dump(5'd5, 5'd5);
        wait_done("single", 2);
        chk_eq("single_words", n_acc - base, 1);

        // Backpressure: five stall cycles on each word.
        regs[0] = 32'h39CE7F9E;
        regs[1] = 32'hC0100420;
        base = n_acc;
        dumpReady = 1'b0;
        start_dump(5'd0, 5'd1);
        for (int w = 0; w < 2; w++) begin
            guard = 0;
            while (!dumpValid && guard < 50) begin
                tick();
                guard++;
            end
            chk_eq("stall_word_seen", dumpValid, 1);
            repeat (5) tick();
            dumpReady = 1'b1;
            tick();
            dumpReady = 1'b0;
        end
        dumpReady = 1'b1;
        wait_done("stall", 13);
        chk_eq("stall_words", n_acc - base, 2);
        regs[0] = 32'd1;
        regs[1] = 32'd2;

        // Start while busy and during DONE are ignored.
        base = n_acc;
        start_dump(5'd4, 5'd9);
        tick();
        startReg = 5'd20; endReg = 5'd25; start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!done && guard < 100) begin
            tick();
            guard++;
        end
        chk_eq("busy_lat", cyc_cnt - t_start, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_eq("done_start_ignored", busy, 0);
        chk_eq("busy_words", n_acc - base, 6);
        chk_eq("busy_sb_empty", sb_q.size(), 0);

        // Reset after the third accepted word aborts the dump with no done.
        base  = n_acc;
        dbase = n_done;
        start_dump(5'd0, 5'd31);
        guard = 0;
        while (n_acc - base < 3 && guard < 100) begin
            tick();
            guard++;
        end
        chk_eq("abort_three_words", n_acc - base, 3);
        rst_n = 1'b0;
        sb_q.delete();
        rd_q.delete();
        tick();
        chk_eq("abort_valid", dumpValid, 0);
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_done", done, 0);
        chk_eq("abort_data", dumpData, 0);
        chk_eq("abort_addr", dumpAddr, 0);
        chk_eq("abort_rr1", readReg1, 0);
        chk_eq("abort_rr2", readReg2, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_eq("abort_no_done", n_done - dbase, 0);
        base = n_acc;
        start_dump(5'd0, 5'd31);
        wait_done("restart", 48);
        chk_eq("restart_words", n_acc - base, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/register_dump_reader.md
REGISTER_DUMP_READER -- requirements
Module: register_dump_reader

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, register data width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  begin a dump; sampled only in IDLE.
REQ-005 SHALL have port: startReg  input  5  first register index, latched at start.
REQ-006 SHALL have port: endReg  input  5  last register index, latched at start.
REQ-007 SHALL have port: readReg1  output  5  register file read address, port 1.
REQ-008 SHALL have port: readReg2  output  5  register file read address, port 2.
REQ-009 SHALL have port: readData1  input  WIDTH  register file read data, port 1 (combinational read).
REQ-010 SHALL have port: readData2  input  WIDTH  register file read data, port 2 (combinational read).
REQ-011 SHALL have port: dumpData  output  WIDTH  streamed register contents.
REQ-012 SHALL have port: dumpAddr  output  5  index of register on dumpData.
REQ-013 SHALL have port: dumpValid  output  1  dumpData/dumpAddr valid.
REQ-014 SHALL have port: dumpReady  input  1  sink accepts word when high with dumpValid.
REQ-015 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port: done  output  1  one-cycle pulse after last word accepted.

Function
REQ-017 SHALL implement FSM states IDLE, READ, SEND1, SEND2, DONE.
REQ-018 IDLE: start=1 at edge N SHALL latch ptr=startReg, remaining=((endReg-startReg) mod 32)+1 (range 1..32, 6-bit), enter READ.
REQ-019 READ: readReg1=ptr, readReg2=(ptr+1) mod 32; next edge SHALL capture readData1/readData2 into buf1/buf2 and enter SEND1.
REQ-020 Outside READ, readReg1/readReg2 SHALL hold last values (0 after reset).
REQ-021 First dumpValid SHALL assert the cycle after edge N+1 (two edges after start sampled).
REQ-022 SEND1: dumpValid=1, dumpData=buf1, dumpAddr=ptr; on dumpValid&dumpReady remaining decrements; if remaining was 1 go DONE, else SEND2.
REQ-023 SEND2: dumpValid=1, dumpData=buf2, dumpAddr=(ptr+1) mod 32; on accept remaining decrements, ptr+=2 mod 32; if remaining was 1 go DONE, else READ.
REQ-024 dumpData/dumpAddr/dumpValid SHALL remain stable while dumpValid=1 and dumpReady=0; no word dropped or duplicated.
REQ-025 dumpValid SHALL be 0 in IDLE, READ and DONE.
REQ-026 Wrap-around: startReg>endReg SHALL dump startReg..31 then 0..endReg; startReg==endReg SHALL dump one word; endReg==(startReg-1) mod 32 SHALL dump all 32.
REQ-027 Pointer arithmetic SHALL be modulo 32; ptr=31 pairs readReg1=31, readReg2=0.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; start during DONE ignored.
REQ-029 start while busy SHALL be ignored; startReg/endReg changes while busy SHALL not affect dump.
REQ-030 Maximum throughput: with dumpReady held high, 2 words per 3 cycles.

Reset
REQ-031 rst_n=0 at any edge SHALL force IDLE; dumpValid=0, done=0, busy=0, dumpData=0, dumpAddr=0, readReg1=0, readReg2=0, buf1=buf2=0, ptr=0, remaining=0.
REQ-032 Reset mid-dump SHALL abort with no done pulse; first start after rst_n=1 SHALL begin a fresh dump.

Verification
REQ-033 Regfile reg k=k+1 for k=0..31; start, startReg=0, endReg=31, dumpReady=1 -> 32 words, addr 0..31, data 1..32, done 1 cycle after addr 31 accepted, 48 cycles start-to-done.
REQ-034 startReg=30, endReg=1 -> addrs 30,31,0,1 with data 31,32,1,2; readReg1=30/readReg2=31 then 0/1.
REQ-035 startReg=endReg=5 -> single word addr 5 data 6, then DONE; SEND2 never entered.
REQ-036 Reg0=32'h39CE7F9E, reg1=32'hC0100420; dumpReady low 5 cycles on each word -> outputs stable throughout, both words delivered once.
REQ-037 rst_n=0 after third accepted word of 0..31 dump -> next cycle all outputs 0, no done; restart yields full dump from addr 0.
REQ-038 start pulsed again while busy -> ignored; word count unchanged.
